fir_channel_scheduler: RTL and testbench
========================================

Name: fir_channel_scheduler

Overview:
- Time-shares one pipelined 16-bit signed FIR core among NUM_CH independent sample streams.
- The FIR core holds a separate delay line per channel, selected by a channel tag.
- Round-robin arbitrates input requesters and issues one sample per cycle to the core.
- Tracks the channel tag through the core latency and returns each result to its channel's output holding register, using valid/ready handshakes on both sides.

Parameters:
- NUM_CH, 4, number of requester channels (2..8).
- DW, 16, sample/result width, signed two's complement.
- CORE_LAT, 3, FIR core cycles from core_valid to core_result valid (>=1).

Ports:
- system1000  input  1  clock, rising edge.
- system1000_rst  input  1  synchronous active-high reset.
- in_valid  input  NUM_CH  per-channel sample offered.
- in_data  input  NUM_CH*DW  channel i sample at bits [i*DW +: DW].
- in_ready  output  NUM_CH  one-hot or zero; combinational grant.
- core_valid  output  1  sample issued to FIR core this cycle.
- core_ch  output  clog2(NUM_CH)  channel tag for core delay-line select.
- core_arg  output  DW  sample to core.
- core_result  input  DW  core output, valid CORE_LAT cycles after matching core_valid.
- out_valid  output  NUM_CH  per-channel result held.
- out_data  output  NUM_CH*DW  per-channel result registers.
- out_ready  input  NUM_CH  per-channel consumer accept.
- busy  output  1  any sample in flight or held.

Behaviour:
Reset:
- in_ready=0, core_valid=0, core_ch=0, core_arg=0, out_valid=0, out_data=0, busy=0.
- RR pointer=0; all credits free; tag pipeline cleared.

Credit:
- Each channel has at most one outstanding sample, counted from input handshake until output handshake.
- Eligible[i] = in_valid[i] & credit_free[i], using the registered credit state.

Arbitration:
- Grant the first eligible channel searching from ptr, ptr+1, ... with modulo NUM_CH wrap.
- in_ready = one-hot grant. Handshake occurs when in_valid[i] & in_ready[i].
- On a grant, ptr <= granted+1 (wraps to 0). With no grant, ptr is held.

Issue:
- Handshake at cycle T gives core_valid=1, core_ch=i, core_arg=sample at T+1, all registered.
- In idle cycles core_valid=0; core_arg/core_ch hold their last values.

Return:
- A tag shift register of CORE_LAT stages ({valid, ch}) aligns with core_result.
- When the tag emerges valid, out_data[ch] <= core_result and out_valid[ch] <= 1 at T+CORE_LAT+2.
- out_valid[i] stays high and out_data[i] stable until out_ready[i].
- Credit frees on the cycle after the output handshake. The same channel can be re-granted at the earliest in the cycle after out_valid falls; a simultaneous free and re-grant in one cycle is prohibited.

Throughput:
- One issue per cycle across channels.
- Per channel: at most one sample per CORE_LAT+3 cycles when out_ready is tied high.

Boundaries:
- All credits busy: in_ready=0 regardless of in_valid.
- A tag arriving for a channel whose out_valid is already set cannot occur (credit guarantees it). An assertion flags it in simulation.
- in_valid dropping without handshake: legal, no state change.
- Reset mid-operation: in-flight tags and held results are discarded, credits are freed, and the core is not flushed. A core delay-line reset is the core's own responsibility on system1000_rst.
- busy = |~credit_free.

Optional Feature:
- Macro: FIR_SCHED_STATS_EN.
- When defined, adds output ports stat_issued (32-bit, increments per input handshake) and stat_stall (32-bit, increments each cycle where |in_valid and no grant). Both wrap at 2^32 and are cleared by reset.
- When undefined, these ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Package fir_sched_pkg: DW, sample_t (signed [DW-1:0]), CH_W = clog2(NUM_CH) function, and the tag struct {valid, ch}.
- Sub-module fir_rr_arbiter (request vector plus pointer in, one-hot grant plus next pointer out), purely combinational and instantiated once.

Test Plan:
- Single channel: ch0 sends 16'sd100 at T with core as identity delay of CORE_LAT=3 -> core_valid/core_ch=0/core_arg=100 at T+1; out_valid[0] with out_data=100 at T+5; busy high T+1..out handshake.
- All 4 in_valid held, out_ready=1111 -> grants 0,1,2,3 on consecutive cycles; ch0 re-granted exactly one cycle after its out_valid falls; no channel starved.
- Backpressure: out_ready[2]=0 for 20 cycles -> ch2 in_ready stays 0 and out_data[2] stable; other channels continue; release -> ch2 resumes.
- Ordering/tagging: core returns arg*2. Send ch1=-5 and ch3=7 back-to-back -> out_data[1]=-10 and out_data[3]=14, with no cross-channel corruption.
- Reset asserted one cycle after issue on ch0 -> all outputs 0 next cycle, no stale out_valid after release, ptr restarts at ch0.
- With FIR_SCHED_STATS_EN: 10 handshakes plus 3 fully-blocked cycles -> stat_issued=10, stat_stall=3; reset clears both to 0.

Source files
------------

// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the FIR channel scheduler.
// Holds sample/tag types and the channel-index width function.
package fir_sched_pkg;

   localparam int DW       = 16;
   localparam int MAX_CH_W = 3;

   typedef logic signed [DW-1:0] sample_t;

   typedef struct packed {
      logic                valid;
      logic [MAX_CH_W-1:0] ch;
   } tag_t;

   function automatic int ch_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fir_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr.
// Returns a one-hot grant and the pointer to use after that grant.
module fir_rr_arbiter #(
   parameter int  NUM_CH = 4,
   localparam int CH_W   = fir_sched_pkg::ch_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   next_ptr
);

   logic found;
   int   idx;

   // Scan from ptr with wrap; first requester wins
   always_comb begin
      grant    = '0;
      next_ptr = ptr;
      found    = 1'b0;
      idx      = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = (int'(ptr) + i) % NUM_CH;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            next_ptr   = (idx == NUM_CH - 1) ? '0 : CH_W'(idx + 1);
         end
      end
   end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Time-shares one pipelined FIR core among NUM_CH sample streams.
// Optional counters stat_issued/stat_stall under FIR_SCHED_STATS_EN.
module fir_channel_scheduler #(
   parameter int  NUM_CH   = 4,
   parameter int  DW       = fir_sched_pkg::DW,
   parameter int  CORE_LAT = 3,
   localparam int CH_W     = fir_sched_pkg::ch_w(NUM_CH)
) (
   input  logic                 system1000,
   input  logic                 system1000_rst,
   input  logic [NUM_CH-1:0]    in_valid,
   input  logic [NUM_CH*DW-1:0] in_data,
   output logic [NUM_CH-1:0]    in_ready,
   output logic                 core_valid,
   output logic [CH_W-1:0]      core_ch,
   output logic [DW-1:0]        core_arg,
   input  logic [DW-1:0]        core_result,
   output logic [NUM_CH-1:0]    out_valid,
   output logic [NUM_CH*DW-1:0] out_data,
   input  logic [NUM_CH-1:0]    out_ready,
`ifdef FIR_SCHED_STATS_EN
   output logic [31:0]          stat_issued,
   output logic [31:0]          stat_stall,
`endif
   output logic                 busy
);

   import fir_sched_pkg::*;

   logic [NUM_CH-1:0] credit_free;
   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] grant;
   logic [NUM_CH-1:0] out_hs;
   logic [CH_W-1:0]   ptr;
   logic [CH_W-1:0]   next_ptr;
   logic [CH_W-1:0]   gnt_ch;
   logic [DW-1:0]     gnt_data;
   logic [CH_W-1:0]   out_ch;
   tag_t              tag_q [CORE_LAT];
   tag_t              tag_out;

   assign eligible = in_valid & credit_free;
   assign in_ready = system1000_rst ? '0 : grant;
   assign out_hs   = out_valid & out_ready;
   assign busy     = ~&credit_free;
   assign tag_out  = tag_q[CORE_LAT-1];
   assign out_ch   = CH_W'(tag_out.ch);

   fir_rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req      (eligible),
      .ptr      (ptr),
      .grant    (grant),
      .next_ptr (next_ptr)
   );

   // Encode the one-hot grant into a channel index and select its sample
   always_comb begin
      gnt_ch   = '0;
      gnt_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) begin
            gnt_ch   = CH_W'(i);
            gnt_data = in_data[i*DW +: DW];
         end
      end
   end

   // Round-robin pointer advances only past a granted channel
   always_ff @(posedge system1000) begin
      if (system1000_rst)
         ptr <= '0;
      else if (|grant)
         ptr <= next_ptr;
   end

   // One credit per channel: taken on input handshake, returned after output handshake
   always_ff @(posedge system1000) begin
      if (system1000_rst)
         credit_free <= '1;
      else
         credit_free <= (credit_free & ~grant) | out_hs;
   end

   // Issue register; tag and sample hold their last value when idle
   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         core_valid <= 1'b0;
         core_ch    <= '0;
         core_arg   <= '0;
      end else begin
         core_valid <= |grant;
         if (|grant) begin
            core_ch  <= gnt_ch;
            core_arg <= gnt_data;
         end
      end
   end

   // Tag shift register keeps the channel aligned with core_result
   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         for (int k = 0; k < CORE_LAT; k++)
            tag_q[k] <= '0;
      end else begin
         tag_q[0] <= '{valid: core_valid, ch: MAX_CH_W'(core_ch)};
         for (int k = 1; k < CORE_LAT; k++)
            tag_q[k] <= tag_q[k-1];
      end
   end

   // Per-channel result holding registers
   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         out_valid <= '0;
         out_data  <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (out_hs[i])
               out_valid[i] <= 1'b0;
            if (tag_out.valid && out_ch == CH_W'(i)) begin
               out_valid[i]         <= 1'b1;
               out_data[i*DW +: DW] <= core_result;
            end
         end
      end
   end

   // Credit makes a result landing on an occupied holding register impossible
   always @(posedge system1000) begin
      if (!system1000_rst && tag_out.valid)
         assert (!out_valid[out_ch]);
   end

`ifdef FIR_SCHED_STATS_EN
   // Issue and stall counters, free-running with natural wrap
   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         if (|grant)
            stat_issued <= stat_issued + 32'd1;
         if (|in_valid && !(|grant))
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed testbench for fir_channel_scheduler with a behavioural core.
// The core model is a CORE_LAT-stage pipeline returning arg*mult.
module tb_fir_channel_scheduler;

   import fir_sched_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  in_valid = '0;
   logic [63:0] in_data = '0;
   logic [3:0]  in_ready;
   logic        core_valid;
   logic [1:0]  core_ch;
   sample_t     core_arg;
   sample_t     core_result;
   logic [3:0]  out_valid;
   logic [63:0] out_data;
   logic [3:0]  out_ready = '0;
   logic        busy;
`ifdef FIR_SCHED_STATS_EN
   logic [31:0] stat_issued;
   logic [31:0] stat_stall;
`endif

   int      tests = 0;
   int      fails = 0;
   sample_t mult = 16'sd1;
   sample_t p0 = '0, p1 = '0, p2 = '0;

   always #5 clk = ~clk;

   // Behavioural FIR core: fixed latency of 3 from core_valid
   always @(posedge clk) begin
      p0 <= core_valid ? sample_t'(core_arg * mult) : '0;
      p1 <= p0;
      p2 <= p1;
   end
   assign core_result = p2;

   fir_channel_scheduler #(
      .NUM_CH   (4),
      .DW       (16),
      .CORE_LAT (3)
   ) dut (
      .system1000     (clk),
      .system1000_rst (rst),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .core_valid     (core_valid),
      .core_ch        (core_ch),
      .core_arg       (core_arg),
      .core_result    (core_result),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_ready      (out_ready),
`ifdef FIR_SCHED_STATS_EN
      .stat_issued    (stat_issued),
      .stat_stall     (stat_stall),
`endif
      .busy           (busy)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst       = 1'b1;
      in_valid  = '0;
      out_ready = '0;
      step;
      step;
      rst     = 1'b0;
      in_data = '0;
   endtask

   task automatic test_reset;
      rst      = 1'b1;
      in_valid = 4'b1111;
      step;
      step;
      tests++;
      if (in_ready !== 4'b0000 || core_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl got rdy=%b cv=%b busy=%b exp 0000 0 0",
                  in_ready, core_valid, busy);
      end
      tests++;
      if (core_ch !== 2'd0 || core_arg !== 16'sd0) begin
         fails++;
         $display("FAIL reset_core got ch=%0d arg=%0d exp 0 0", core_ch, core_arg);
      end
      tests++;
      if (out_valid !== 4'b0000 || out_data !== 64'd0) begin
         fails++;
         $display("FAIL reset_out got ov=%b od=%h exp 0 0", out_valid, out_data);
      end
      in_valid = '0;
      rst      = 1'b0;
   endtask

   task automatic test_single;
      do_reset;
      mult            = 16'sd1;
      out_ready       = 4'b1111;
      in_data[15:0]   = 16'sd100;
      in_valid        = 4'b0001;
      #1;
      tests++;
      if (in_ready !== 4'b0001) begin
         fails++;
         $display("FAIL single_grant got %b exp 0001", in_ready);
      end
      step;
      in_valid = '0;
      tests++;
      if (core_valid !== 1'b1 || core_ch !== 2'd0 || core_arg !== 16'sd100 || busy !== 1'b1) begin
         fails++;
         $display("FAIL single_issue got cv=%b ch=%0d arg=%0d busy=%b exp 1 0 100 1",
                  core_valid, core_ch, core_arg, busy);
      end
      step;
      step;
      step;
      tests++;
      if (out_valid !== 4'b0000 || busy !== 1'b1) begin
         fails++;
         $display("FAIL single_t4 got ov=%b busy=%b exp 0000 1", out_valid, busy);
      end
      step;
      tests++;
      if (out_valid !== 4'b0001 || $signed(out_data[15:0]) !== 16'sd100 || busy !== 1'b1) begin
         fails++;
         $display("FAIL single_out got ov=%b od=%0d busy=%b exp 0001 100 1",
                  out_valid, $signed(out_data[15:0]), busy);
      end
      step;
      tests++;
      if (out_valid !== 4'b0000 || busy !== 1'b0 || core_valid !== 1'b0 || core_arg !== 16'sd100) begin
         fails++;
         $display("FAIL single_done got ov=%b busy=%b cv=%b arg=%0d exp 0000 0 0 100",
                  out_valid, busy, core_valid, core_arg);
      end
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_g [12] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0,
                                 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
      do_reset;
      out_ready = 4'b1111;
      in_data   = 64'h0004_0003_0002_0001;
      in_valid  = 4'b1111;
      for (int k = 0; k < 12; k++) begin
         #1;
         tests++;
         if (in_ready !== exp_g[k]) begin
            fails++;
            $display("FAIL rr_grant_c%0d got %b exp %b", k, in_ready, exp_g[k]);
         end
         if (k == 5 || k == 6) begin
            tests++;
            if (out_valid[0] !== (k == 5)) begin
               fails++;
               $display("FAIL rr_ov0_c%0d got %b exp %b", k, out_valid[0], k == 5);
            end
         end
         step;
      end
      in_valid = '0;
      repeat (8) step;
   endtask

   task automatic test_backpressure;
      int g0;
      int waited;
      do_reset;
      mult           = 16'sd1;
      out_ready      = 4'b1011;
      in_data        = 64'h0004_0037_0002_0001;
      in_valid       = 4'b0100;
      step;
      in_valid = '0;
      repeat (4) step;
      tests++;
      if (out_valid[2] !== 1'b1 || out_data[47:32] !== 16'd55) begin
         fails++;
         $display("FAIL bp_held got ov=%b od=%0d exp 1 55", out_valid[2], out_data[47:32]);
      end
      in_valid = 4'b1111;
      g0 = 0;
      for (int k = 0; k < 20; k++) begin
         #1;
         tests++;
         if (in_ready[2] !== 1'b0 || out_data[47:32] !== 16'd55 || out_valid[2] !== 1'b1) begin
            fails++;
            $display("FAIL bp_stall_c%0d got rdy2=%b od=%0d ov=%b exp 0 55 1",
                     k, in_ready[2], out_data[47:32], out_valid[2]);
         end
         if (in_ready[0])
            g0++;
         step;
      end
      tests++;
      if (g0 < 2) begin
         fails++;
         $display("FAIL bp_others got %0d ch0 grants exp >=2", g0);
      end
      out_ready       = 4'b1111;
      in_data[47:32]  = 16'd66;
      waited          = 0;
      #1;
      while (!in_ready[2] && waited < 10) begin
         step;
         waited++;
      end
      tests++;
      if (in_ready[2] !== 1'b1) begin
         fails++;
         $display("FAIL bp_resume got rdy2=%b after %0d cycles exp 1", in_ready[2], waited);
      end
      step;
      in_valid = '0;
      repeat (7) step;
      tests++;
      if (out_data[47:32] !== 16'd66) begin
         fails++;
         $display("FAIL bp_newdata got %0d exp 66", out_data[47:32]);
      end
      repeat (4) step;
   endtask

   task automatic test_ordering;
      do_reset;
      mult            = 16'sd2;
      out_ready       = 4'b1111;
      in_data[31:16]  = -16'sd5;
      in_valid        = 4'b0010;
      #1;
      tests++;
      if (in_ready !== 4'b0010) begin
         fails++;
         $display("FAIL ord_g1 got %b exp 0010", in_ready);
      end
      step;
      in_data[63:48] = 16'sd7;
      in_valid       = 4'b1000;
      #1;
      tests++;
      if (in_ready !== 4'b1000) begin
         fails++;
         $display("FAIL ord_g3 got %b exp 1000", in_ready);
      end
      step;
      in_valid = '0;
      step;
      step;
      step;
      tests++;
      if (out_valid !== 4'b0010 || $signed(out_data[31:16]) !== -16'sd10) begin
         fails++;
         $display("FAIL ord_ch1 got ov=%b od=%0d exp 0010 -10",
                  out_valid, $signed(out_data[31:16]));
      end
      step;
      tests++;
      if (out_valid !== 4'b1000 || $signed(out_data[63:48]) !== 16'sd14 ||
          $signed(out_data[31:16]) !== -16'sd10) begin
         fails++;
         $display("FAIL ord_ch3 got ov=%b od3=%0d od1=%0d exp 1000 14 -10",
                  out_valid, $signed(out_data[63:48]), $signed(out_data[31:16]));
      end
      tests++;
      if (out_data[15:0] !== 16'd0 || out_data[47:32] !== 16'd0) begin
         fails++;
         $display("FAIL ord_clean got od0=%h od2=%h exp 0 0", out_data[15:0], out_data[47:32]);
      end
      step;
      mult = 16'sd1;
   endtask

   task automatic test_reset_mid;
      do_reset;
      mult          = 16'sd1;
      out_ready     = 4'b1111;
      in_data[15:0] = 16'sd100;
      in_valid      = 4'b0001;
      step;
      in_valid = '0;
      rst      = 1'b1;
      step;
      tests++;
      if (core_valid !== 1'b0 || core_arg !== 16'sd0 || out_valid !== 4'b0000 ||
          out_data !== 64'd0 || busy !== 1'b0 || in_ready !== 4'b0000) begin
         fails++;
         $display("FAIL rstmid_clear got cv=%b arg=%0d ov=%b od=%h busy=%b rdy=%b exp all 0",
                  core_valid, core_arg, out_valid, out_data, busy, in_ready);
      end
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step;
         tests++;
         if (out_valid !== 4'b0000) begin
            fails++;
            $display("FAIL rstmid_stale_c%0d got %b exp 0000", k, out_valid);
         end
      end
      in_valid = 4'b1111;
      #1;
      tests++;
      if (in_ready !== 4'b0001) begin
         fails++;
         $display("FAIL rstmid_ptr got %b exp 0001", in_ready);
      end
      step;
      in_valid = '0;
      repeat (8) step;
   endtask

`ifdef FIR_SCHED_STATS_EN
   task automatic test_stats;
      do_reset;
      out_ready = 4'b1111;
      in_valid  = 4'b1111;
      repeat (11) step;
      in_valid = '0;
      step;
      in_valid = 4'b0011;
      step;
      step;
      in_valid = '0;
      step;
      tests++;
      if (stat_issued !== 32'd10 || stat_stall !== 32'd3) begin
         fails++;
         $display("FAIL stats_count got iss=%0d stall=%0d exp 10 3", stat_issued, stat_stall);
      end
      rst = 1'b1;
      step;
      rst = 1'b0;
      tests++;
      if (stat_issued !== 32'd0 || stat_stall !== 32'd0) begin
         fails++;
         $display("FAIL stats_reset got iss=%0d stall=%0d exp 0 0", stat_issued, stat_stall);
      end
      repeat (8) step;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_single;
      test_round_robin;
      test_backpressure;
      test_ordering;
      test_reset_mid;
`ifdef FIR_SCHED_STATS_EN
      test_stats;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
